// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the five-stage pipeline. Generates the
// enable/clear controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and
// the PC write enable. It stalls on load-use hazards and on mult/div unit
// occupancy, and flushes IF/ID on a taken branch. It also sequences the
// multi-cycle mult/div unit by issuing a registered start pulse and tracking
// the unit's busy window with a down-counter.

module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dst,
    input  logic       id_md_op,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_branch_taken,
    output logic       pc_en,
    output logic       en_fd,
    output logic       en_de,
    output logic       en_em,
    output logic       en_mw,
    output logic       clr_fd,
    output logic       clr_de,
    output logic       clr_em,
    output logic       clr_mw,
    output logic       md_start,
    output logic       md_busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_START = 2'd1,
        MD_BUSY  = 2'd2
    } md_state_t;

    md_state_t       state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   len;

    logic md_op_eff;
    logic load_use;
    logic md_stall;
    logic stall;
    logic flush;

    // A start op in ID also counts as an MD access.
    assign md_op_eff = id_md_op | id_md_start;
    assign md_busy   = (cnt != '0);

    // Hazard detection: load-use against EX, and MD access while the unit is occupied.
    always_comb begin
        load_use = ex_mem_read && (ex_dst != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_dst)) ||
                    (id_uses_rt && (id_rt == ex_dst)));
        md_stall = md_op_eff && (md_start || md_busy);
        stall    = load_use || md_stall;
        // A stall holds the branch in ID, so it re-resolves later instead of flushing now.
        flush    = id_branch_taken && !stall;
    end

    // Pipeline register and PC controls, combinational from inputs and MD state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_en  = 1'b1;
        en_fd  = 1'b1;
        en_de  = 1'b1;
        en_em  = 1'b1;
        en_mw  = 1'b1;
        clr_fd = 1'b0;
        clr_de = 1'b0;
        clr_em = 1'b0;
        clr_mw = 1'b0;
        if (reset) begin
            pc_en  = 1'b0;
            en_fd  = 1'b0;
            en_de  = 1'b0;
            en_em  = 1'b0;
            en_mw  = 1'b0;
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            clr_mw = 1'b1;
        end else if (stall) begin
            // Hold IF and ID, push a bubble into EX; later stages keep flowing.
            pc_en  = 1'b0;
            en_fd  = 1'b0;
            clr_de = 1'b1;
        end else if (flush) begin
            // No delay slot: the fetched instruction after a taken branch is discarded.
            clr_fd = 1'b1;
        end
    end

    // MD sequencer: IDLE -> START (one-cycle start pulse) -> BUSY (count down) -> IDLE.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (reset) begin
            state    <= MD_IDLE;
            md_start <= 1'b0;
            cnt      <= '0;
            len      <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (id_md_start && !stall) begin
                        state    <= MD_START;
                        md_start <= 1'b1;
                        len      <= id_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end
                end
                MD_START: begin
                    md_start <= 1'b0;
                    cnt      <= len;
                    state    <= (len == '0) ? MD_IDLE : MD_BUSY;
                end
                MD_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= MD_IDLE;
                    end
                end
                default: begin
                    state    <= MD_IDLE;
                    md_start <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule
